ctag_ctrl: RTL and testbench
============================

Name: ctag_ctrl

Overview:
Control stage directly upstream of the 1024x14 cache tag array. Drives the array's address, write data and active-low write strobe; consumes its read data. Serves CPU lookups (tag compare, hit/miss, parity check), line fills, single-line DMA invalidates and a full-array flush sweep. Only one operation is in flight at a time, arbitrated by fixed priority.

Parameters:
IDX_W, 10, index width (1024 lines)
TAG_W, 12, stored tag width
FLUSH_LAST, 1023, final index of the flush sweep

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
PA  in  24  physical address; index = PA[11:2], tag = PA[23:12]
LOOK_REQ  in  1  lookup request
FILL_REQ  in  1  write the tag of PA, valid=1
INV_REQ  in  1  clear the valid bit of the line at PA index
FLUSH_REQ  in  1  invalidate all lines
ACK  out  1  one-cycle pulse: the operation accepted earlier has completed
HIT  out  1  lookup result, valid with ACK
PERR  out  1  parity error on the lookup, valid with ACK
BUSY  out  1  state != IDLE
TA  out  10  tag array address
TD  out  14  tag array write data: [11:0] tag, [12] valid, [13] odd parity over [12:0]
TQ  in  14  tag array read data (combinational RAM output)
TnWE  out  1  tag array write enable, active low

Behaviour:
- Reset, asynchronous: state=IDLE, ACK=0, HIT=0, PERR=0, BUSY=0, TA=0, TD=0, TnWE=1, flush counter=0.
- Priority, sampled only in IDLE: FLUSH > INV > FILL > LOOK. Requests arriving outside IDLE are ignored; the requester holds its request until it sees ACK.
- The PA index and tag are latched into TA and a tag register on acceptance.
- States: IDLE, LOOK, WSET, WPUL, FSET, FPUL, DONE.
- LOOK (1 cycle, TnWE=1): at the clock edge, HIT <= TQ[12] & (TQ[11:0]==tag) & parity_ok; PERR <= ~parity_ok; go to DONE. A parity error forces HIT=0.
- WSET: TD is valid, TnWE=1 (address/data setup cycle). WPUL: TnWE=0 for exactly one cycle, then DONE.
  - FILL: TD = {par, 1, tag}.
  - INV: TD = {par, 0, 12'h000}.
- FLUSH: counter <= 0; TA = counter; TD = {1, 0, 0}, whose parity is valid. Alternates FSET (TnWE=1) and FPUL (TnWE=0). After FPUL:
  - if counter == FLUSH_LAST, go to DONE;
  - otherwise counter+1, then FSET.
  - The flush takes 2048 cycles plus one DONE cycle.
- DONE: ACK=1 for one cycle, return to IDLE. HIT/PERR hold until the next lookup completes.
- TA and TD change only in cycles where TnWE=1 (no change during or entering a write pulse). TnWE is registered and glitch-free.
- Boundary cases:
  - Counter wrap 1023→0 must not occur; flush ends at FLUSH_LAST.
  - Simultaneous requests are resolved by priority; a losing request stays pending.
  - RST during WPUL/FPUL forces TnWE=1 asynchronously; the array contents are then undefined for that line.
- Latency from acceptance to ACK: lookup 2 cycles, fill/invalidate 3, flush 2*(FLUSH_LAST+1)+1.

Decomposition:
- Shared package: state encoding enum, TAG_W/IDX_W constants, tag field bit positions (valid=12, parity=13), and an odd-parity function.
- One sub-module, ctag_parity: 13-bit odd-parity generator/checker. It is used both for TD generation and for TQ checking.

Test Plan:
- Reset mid-flush (RST asserted at counter=300 while in FPUL) -> TnWE=1 immediately, BUSY=0, next FLUSH restarts from index 0.
- FILL PA=24'hABC123 -> TA=10'h048, TD=14'b1_1_101010111100 with the correct odd parity, TnWE low exactly 1 cycle, ACK at cycle 3. Then LOOK on the same PA -> HIT=1, PERR=0, ACK at cycle 2.
- LOOK PA=24'hABD123 (same index, tag differs) after that fill -> HIT=0, PERR=0.
- INV on index 10'h048, then LOOK PA=24'hABC123 -> HIT=0. Bench array model shows valid=0 with parity consistent.
- Bench model corrupts TQ[13] at index 10'h048 after a fill; LOOK -> PERR=1, HIT=0.
- FLUSH_REQ and LOOK_REQ asserted together -> flush wins, 1024 TnWE pulses at addresses 0..1023 in order, ACK at cycle 2049. The held LOOK is accepted on the following IDLE cycle and returns HIT=0.

Source files
------------

// File: rtl/ctag_ctrl_pkg.sv
// Shared constants, state encoding and parity helper for the cache tag control stage.
package ctag_ctrl_pkg;

  localparam int IDX_W   = 10;
  localparam int TAG_W   = 12;
  localparam int TD_W    = 14;
  localparam int VLD_BIT = 12;
  localparam int PAR_BIT = 13;

  // Last index written by the flush sweep; the counter stops here and never wraps.
  localparam logic [IDX_W-1:0] FLUSH_LAST = 10'd1023;

  // State encoding (plain constants so older tools and checkers can share them).
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOOK = 3'd1;
  localparam logic [2:0] ST_WSET = 3'd2;
  localparam logic [2:0] ST_WPUL = 3'd3;
  localparam logic [2:0] ST_FSET = 3'd4;
  localparam logic [2:0] ST_FPUL = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  // Odd parity bit for a 13-bit tag entry: the full 14-bit word carries an odd number of ones.
  function automatic logic odd_par(input logic [PAR_BIT-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/ctag_ctrl_if.sv
// Bundle of the requester handshake and the tag array port.
// Handshake: a requester raises exactly one *_REQ (or several; FLUSH > INV > FILL > LOOK)
// with PA stable and holds it until it observes ACK high for one cycle; requests are only
// sampled while BUSY is low, so a held request that loses arbitration simply waits.
// HIT/PERR are meaningful in the ACK cycle of a lookup and hold until the next lookup ends.
interface ctag_ctrl_if;
  import ctag_ctrl_pkg::*;

  logic [23:0]       PA;
  logic              LOOK_REQ;
  logic              FILL_REQ;
  logic              INV_REQ;
  logic              FLUSH_REQ;
  logic              ACK;
  logic              HIT;
  logic              PERR;
  logic              BUSY;
  logic [IDX_W-1:0]  TA;
  logic [TD_W-1:0]   TD;
  logic [TD_W-1:0]   TQ;
  logic              TnWE;

  // Environment side: requester plus the tag array itself.
  modport master (
    output PA, LOOK_REQ, FILL_REQ, INV_REQ, FLUSH_REQ, TQ,
    input  ACK, HIT, PERR, BUSY, TA, TD, TnWE
  );

  // Controller side.
  modport slave (
    input  PA, LOOK_REQ, FILL_REQ, INV_REQ, FLUSH_REQ, TQ,
    output ACK, HIT, PERR, BUSY, TA, TD, TnWE
  );

endinterface

// File: rtl/ctag_parity.sv
// 13-bit odd-parity generator; checking is done by comparing against a stored parity bit.
module ctag_parity
  import ctag_ctrl_pkg::*;
(
  input  logic [PAR_BIT-1:0] data,
  output logic               par
);

  assign par = odd_par(data);

endmodule

// File: rtl/ctag_ctrl.sv
// Cache tag array control stage: lookup, fill, single-line invalidate and full flush sweep.
// One operation at a time; array address/data are registered and only move while TnWE is high.
module ctag_ctrl
  import ctag_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  ctag_ctrl_if.slave  bus
);

  logic [2:0]        state_q, state_d;
  logic [IDX_W-1:0]  ta_q, ta_d;
  logic [TD_W-1:0]   td_q, td_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              we_n_q, we_n_d;
  logic              ack_q, ack_d;
  logic              hit_q, hit_d;
  logic              perr_q, perr_d;

  logic [IDX_W-1:0]  pa_idx;
  logic [TAG_W-1:0]  pa_tag;
  logic              fill_par;
  logic              tq_par;
  logic              parity_ok;
  logic [TD_W-1:0]   td_clear;
  logic              unused_pa;

  assign pa_idx    = bus.PA[11:2];
  assign pa_tag    = bus.PA[23:12];
  assign unused_pa = ^bus.PA[1:0];

  // Parity for a fill entry (valid=1 plus the new tag).
  ctag_parity u_fill_par (
    .data ({1'b1, pa_tag}),
    .par  (fill_par)
  );

  // Expected parity of the word currently read from the array.
  ctag_parity u_chk_par (
    .data (bus.TQ[VLD_BIT:0]),
    .par  (tq_par)
  );

  assign parity_ok = (bus.TQ[PAR_BIT] == tq_par);

  // Invalid entry with a consistent parity bit, used by invalidate and flush.
  assign td_clear = {odd_par(13'h0000), 13'h0000};

  // Next-state and datapath decode; TnWE low is only ever requested for the pulse states.
  always_comb begin
    state_d = state_q;
    ta_d    = ta_q;
    td_d    = td_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    perr_d  = perr_q;
    we_n_d  = 1'b1;
    ack_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.FLUSH_REQ) begin
          cnt_d   = '0;
          ta_d    = '0;
          td_d    = td_clear;
          state_d = ST_FSET;
        end else if (bus.INV_REQ) begin
          ta_d    = pa_idx;
          tag_d   = pa_tag;
          td_d    = td_clear;
          state_d = ST_WSET;
        end else if (bus.FILL_REQ) begin
          ta_d    = pa_idx;
          tag_d   = pa_tag;
          td_d    = {fill_par, 1'b1, pa_tag};
          state_d = ST_WSET;
        end else if (bus.LOOK_REQ) begin
          ta_d    = pa_idx;
          tag_d   = pa_tag;
          state_d = ST_LOOK;
        end
      end
      ST_LOOK: begin
        hit_d   = bus.TQ[VLD_BIT] & (bus.TQ[TAG_W-1:0] == tag_q) & parity_ok;
        perr_d  = ~parity_ok;
        ack_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_WSET: begin
        we_n_d  = 1'b0;
        state_d = ST_WPUL;
      end
      ST_WPUL: begin
        ack_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_FSET: begin
        we_n_d  = 1'b0;
        state_d = ST_FPUL;
      end
      ST_FPUL: begin
        if (cnt_q == FLUSH_LAST) begin
          ack_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = cnt_q + 10'd1;
          ta_d    = cnt_q + 10'd1;
          state_d = ST_FSET;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset releases the write strobe immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ta_q    <= '0;
      td_q    <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      we_n_q  <= 1'b1;
      ack_q   <= 1'b0;
      hit_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ta_q    <= ta_d;
      td_q    <= td_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      we_n_q  <= we_n_d;
      ack_q   <= ack_d;
      hit_q   <= hit_d;
      perr_q  <= perr_d;
    end
  end

  assign bus.ACK  = ack_q;
  assign bus.HIT  = hit_q;
  assign bus.PERR = perr_q;
  assign bus.BUSY = (state_q != ST_IDLE);
  assign bus.TA   = ta_q;
  assign bus.TD   = td_q;
  assign bus.TnWE = we_n_q;

endmodule

// File: tb/tb_ctag_ctrl.sv
// Bench for ctag_ctrl: behavioural tag array, request driver, ACK scoreboard and write monitor.
module tb_ctag_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctag_ctrl_if bus();

  ctag_ctrl dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // ---------------- tag array model ----------------
  logic [13:0] mem [1024];
  logic        mem_init;
  logic        corrupt;
  logic [9:0]  corrupt_idx;

  assign bus.TQ = mem[bus.TA];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 14'h2000;
    end else if (!bus.TnWE) begin
      mem[bus.TA] <= bus.TD;
    end else if (corrupt) begin
      mem[corrupt_idx] <= mem[corrupt_idx] ^ 14'h2000;
    end
  end

  // ---------------- bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int last_idle = 0;

  logic [14:0] exp_q[$];   // {latency[11:0], check_hit_perr, hit, perr}
  logic [23:0] wr_log[$];  // {TA, TD} of each write pulse

  logic        prev_we = 1'b1;
  logic [9:0]  prev_ta = '0;
  logic [13:0] prev_td = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int lat, input logic chk, input logic hit, input logic perr);
    logic [11:0] l;
    l = lat[11:0];
    exp_q.push_back({l, chk, hit, perr});
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: scoreboard on ACK, plus write-pulse shape and address/data stability.
  always @(negedge clk) begin
    logic [14:0] e;
    if (!rst) begin
      if (bus.ACK) begin
        if (exp_q.size() == 0) begin
          check("spurious_ack", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_latency", cyc - last_idle, {20'd0, e[14:3]});
          if (e[2]) begin
            check("hit", {31'd0, bus.HIT}, {31'd0, e[1]});
            check("perr", {31'd0, bus.PERR}, {31'd0, e[0]});
          end
        end
      end
      if (!bus.BUSY) last_idle <= cyc;
      if (!bus.TnWE) begin
        check("we_pulse_single", {31'd0, prev_we}, 32'd1);
        check("ta_stable", {22'd0, bus.TA}, {22'd0, prev_ta});
        check("td_stable", {18'd0, bus.TD}, {18'd0, prev_td});
        wr_log.push_back({bus.TA, bus.TD});
      end
    end
    prev_we <= bus.TnWE;
    prev_ta <= bus.TA;
    prev_td <= bus.TD;
  end

  // ---------------- driver ----------------
  task automatic wait_ack(input int budget, input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.ACK) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check(name, 32'd0, 32'd1);
    #1;
  endtask

  // kind: 0 lookup, 1 fill, 2 invalidate, 3 flush
  task automatic do_op(input int kind, input logic [23:0] pa);
    @(negedge clk);
    #1;
    bus.PA = pa;
    case (kind)
      0: bus.LOOK_REQ  = 1'b1;
      1: bus.FILL_REQ  = 1'b1;
      2: bus.INV_REQ   = 1'b1;
      default: bus.FLUSH_REQ = 1'b1;
    endcase
    wait_ack(3000, "ack_timeout");
    bus.LOOK_REQ  = 1'b0;
    bus.FILL_REQ  = 1'b0;
    bus.INV_REQ   = 1'b0;
    bus.FLUSH_REQ = 1'b0;
  endtask

  task automatic check_flush_log(input string name);
    int bad;
    bad = 0;
    check({name, "_count"}, wr_log.size(), 32'd1024);
    for (int i = 0; i < wr_log.size(); i++) begin
      if (wr_log[i][23:14] != i[9:0] || wr_log[i][13:0] != 14'h2000) bad++;
    end
    check({name, "_order"}, bad, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst           = 1'b1;
    mem_init      = 1'b1;
    corrupt       = 1'b0;
    corrupt_idx   = '0;
    bus.PA        = '0;
    bus.LOOK_REQ  = 1'b0;
    bus.FILL_REQ  = 1'b0;
    bus.INV_REQ   = 1'b0;
    bus.FLUSH_REQ = 1'b0;
    repeat (3) @(negedge clk);
    mem_init = 1'b0;

    // Reset state
    check("rst_ack",  {31'd0, bus.ACK},  32'd0);
    check("rst_hit",  {31'd0, bus.HIT},  32'd0);
    check("rst_perr", {31'd0, bus.PERR}, 32'd0);
    check("rst_busy", {31'd0, bus.BUSY}, 32'd0);
    check("rst_ta",   {22'd0, bus.TA},   32'd0);
    check("rst_td",   {18'd0, bus.TD},   32'd0);
    check("rst_tnwe", {31'd0, bus.TnWE}, 32'd1);
    #1 rst = 1'b0;

    // Reset in the middle of a flush while the strobe is low at index 300
    @(negedge clk);
    #1 bus.FLUSH_REQ = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!bus.TnWE && bus.TA == 10'd300) begin
        found = 1'b1;
        break;
      end
    end
    check("reach_idx300", {31'd0, found}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_tnwe", {31'd0, bus.TnWE}, 32'd1);
    check("midrst_busy", {31'd0, bus.BUSY}, 32'd0);
    check("midrst_ta",   {22'd0, bus.TA},   32'd0);
    bus.FLUSH_REQ = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    wr_log.delete();

    // Fresh flush restarts from index 0 and covers the whole array
    push_exp(2049, 1'b0, 1'b0, 1'b0);
    do_op(3, 24'h0);
    check_flush_log("flush1");

    // Fill PA=ABC123: index 0x048, TD = {1,1,0xABC} = 0x3ABC
    wr_log.delete();
    push_exp(3, 1'b0, 1'b0, 1'b0);
    do_op(1, 24'hABC123);
    check("fill_nwrites", wr_log.size(), 32'd1);
    if (wr_log.size() > 0) begin
      check("fill_ta", {22'd0, wr_log[0][23:14]}, 32'h048);
      check("fill_td", {18'd0, wr_log[0][13:0]},  32'h3ABC);
    end
    check("fill_mem", {18'd0, mem[10'h048]}, 32'h3ABC);

    // Lookups: hit on same tag, miss on different tag at same index
    push_exp(2, 1'b1, 1'b1, 1'b0);
    do_op(0, 24'hABC123);
    push_exp(2, 1'b1, 1'b0, 1'b0);
    do_op(0, 24'hABD123);

    // Corrupted parity bit: PERR set, HIT forced low
    @(negedge clk);
    corrupt_idx = 10'h048;
    corrupt     = 1'b1;
    @(negedge clk);
    corrupt     = 1'b0;
    check("corrupt_mem", {18'd0, mem[10'h048]}, 32'h1ABC);
    push_exp(2, 1'b1, 1'b0, 1'b1);
    do_op(0, 24'hABC123);

    // Refill then hit again (PERR must clear)
    push_exp(3, 1'b0, 1'b0, 1'b0);
    do_op(1, 24'hABC123);
    push_exp(2, 1'b1, 1'b1, 1'b0);
    do_op(0, 24'hABC123);

    // Invalidate index 0x048, then lookup misses
    wr_log.delete();
    push_exp(3, 1'b0, 1'b0, 1'b0);
    do_op(2, 24'hABC123);
    check("inv_nwrites", wr_log.size(), 32'd1);
    if (wr_log.size() > 0) begin
      check("inv_ta", {22'd0, wr_log[0][23:14]}, 32'h048);
      check("inv_td", {18'd0, wr_log[0][13:0]},  32'h2000);
    end
    check("inv_mem", {18'd0, mem[10'h048]}, 32'h2000);
    push_exp(2, 1'b1, 1'b0, 1'b0);
    do_op(0, 24'hABC123);

    // Refill, then FLUSH and LOOK together: flush wins, held lookup then misses
    push_exp(3, 1'b0, 1'b0, 1'b0);
    do_op(1, 24'hABC123);
    wr_log.delete();
    push_exp(2049, 1'b0, 1'b0, 1'b0);
    push_exp(2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    bus.PA        = 24'hABC123;
    bus.FLUSH_REQ = 1'b1;
    bus.LOOK_REQ  = 1'b1;
    wait_ack(3000, "flush_ack_timeout");
    bus.FLUSH_REQ = 1'b0;
    wait_ack(20, "held_look_timeout");
    bus.LOOK_REQ  = 1'b0;
    check_flush_log("flush2");

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
